// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: round-robin arbiter for two requesters feeding one I2C byte engine,
// sequencing START / device / memory address / data / STOP with NACK and timeout handling.
module i2c_xfer_sequencer #(
  parameter int          LEN_W   = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter int          TO_W    = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [1:0]         req,
  input  logic [1:0]         req_rw,
  input  logic [13:0]        req_dev,
  input  logic [15:0]        req_adr,
  input  logic [2*LEN_W-1:0] req_len,
  input  logic [15:0]        req_wdata,
  output logic [1:0]         gnt,
  output logic               wpop,
  output logic [7:0]         rdata,
  output logic               rvalid,
  output logic               done,
  output logic [1:0]         err_code,
  output logic               cmd_valid,
  output logic               cmd_start,
  output logic               cmd_stop,
  output logic               cmd_write,
  output logic               cmd_read,
  output logic               cmd_ack,
  output logic [7:0]         cmd_txd,
  input  logic               cmd_done,
  input  logic [7:0]         core_rxd,
  input  logic               core_rxack,
  output logic               core_abort
);
  typedef enum logic [2:0] {IDLE, DEV_W, MADR, WDAT, RSTA, RDAT, STOP, DONE} state_t;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 16'd1);
  state_t            state_q;
  logic              rr_q, sel_q, rw_q;
  logic [6:0]        dev_q;
  logic [7:0]        adr_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [1:0]        err_q;
  logic [TO_W-1:0]   to_q;
  logic              pick_d, start_d, stop_d, write_d, read_d, ack_d;
  logic [7:0]        txd_d, wd_d;
  always_comb begin
    pick_d  = (req == 2'b11) ? rr_q : req[1];
    wd_d    = sel_q ? req_wdata[15:8] : req_wdata[7:0];
    start_d = state_q inside {DEV_W, RSTA};
    write_d = state_q inside {DEV_W, MADR, WDAT, RSTA};
    read_d  = state_q == RDAT;
    stop_d  = state_q == STOP;
    ack_d   = (state_q == RDAT) && (cnt_q == '0);
    txd_d   = state_q == DEV_W ? {dev_q, 1'b0} :
              state_q == MADR  ? adr_q :
              state_q == WDAT  ? wd_d :
              state_q == RSTA  ? {dev_q, 1'b1} : 8'h00;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      {rr_q, sel_q, rw_q, dev_q, adr_q, len_q, cnt_q, err_q, to_q} <= '0;
      {gnt, wpop, rdata, rvalid, done, err_code, core_abort} <= '0;
      {cmd_valid, cmd_start, cmd_stop, cmd_write, cmd_read, cmd_ack, cmd_txd} <= '0;
    end else begin
      wpop       <= 1'b0;
      rvalid     <= 1'b0;
      done       <= 1'b0;
      core_abort <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          gnt     <= pick_d ? 2'b10 : 2'b01;
          sel_q   <= pick_d;
          rr_q    <= ~pick_d;
          rw_q    <= pick_d ? req_rw[1] : req_rw[0];
          dev_q   <= pick_d ? req_dev[13:7] : req_dev[6:0];
          adr_q   <= pick_d ? req_adr[15:8] : req_adr[7:0];
          len_q   <= pick_d ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
          err_q   <= 2'b00;
          state_q <= DEV_W;
        end
        DONE: begin
          gnt     <= 2'b00;
          state_q <= IDLE;
        end
        default: if (!cmd_valid) begin
          cmd_valid <= 1'b1;
          cmd_start <= start_d;
          cmd_stop  <= stop_d;
          cmd_write <= write_d;
          cmd_read  <= read_d;
          cmd_ack   <= ack_d;
          cmd_txd   <= txd_d;
          to_q      <= '0;
        end else if (cmd_done) begin
          cmd_valid <= 1'b0;
          if (core_rxack && state_q inside {DEV_W, MADR, RSTA}) begin
            err_q   <= 2'b01;
            state_q <= STOP;
          end else if (core_rxack && state_q == WDAT) begin
            err_q   <= 2'b10;
            state_q <= STOP;
          end else begin
            case (state_q)
              DEV_W: state_q <= MADR;
              MADR: begin
                cnt_q   <= len_q;
                state_q <= rw_q ? RSTA : WDAT;
              end
              RSTA: state_q <= RDAT;
              WDAT, RDAT: begin
                wpop    <= state_q == WDAT;
                rvalid  <= state_q == RDAT;
                rdata   <= state_q == RDAT ? core_rxd : rdata;
                cnt_q   <= cnt_q - 1'b1;
                state_q <= cnt_q == '0 ? STOP : state_q;
              end
              default: begin
                done     <= 1'b1;
                err_code <= err_q;
                state_q  <= DONE;
              end
            endcase
          end
        end else if (to_q == TO_LAST) begin
          // abandon the stuck command without a STOP; engine is forced idle instead
          cmd_valid  <= 1'b0;
          core_abort <= 1'b1;
          done       <= 1'b1;
          err_code   <= 2'b11;
          state_q    <= DONE;
        end else begin
          to_q <= to_q + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb_i2c_xfer_sequencer: scoreboard bench with a behavioural byte engine and two requesters.
module tb_i2c_xfer_sequencer;
  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  req, req_rw;
  logic [13:0] req_dev;
  logic [15:0] req_adr;
  logic [7:0]  req_len;
  logic [15:0] req_wdata;
  logic [1:0]  gnt, err_code;
  logic        wpop, rvalid, done, cmd_valid, cmd_start, cmd_stop, cmd_write, cmd_read, cmd_ack;
  logic [7:0]  rdata, cmd_txd, core_rxd;
  logic        cmd_done, core_rxack, core_abort;

  i2c_xfer_sequencer #(.LEN_W(4), .TIMEOUT(16'd20), .TO_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_rw(req_rw), .req_dev(req_dev),
    .req_adr(req_adr), .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .wpop(wpop),
    .rdata(rdata), .rvalid(rvalid), .done(done), .err_code(err_code), .cmd_valid(cmd_valid),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_write(cmd_write), .cmd_read(cmd_read),
    .cmd_ack(cmd_ack), .cmd_txd(cmd_txd), .cmd_done(cmd_done), .core_rxd(core_rxd),
    .core_rxack(core_rxack), .core_abort(core_abort));

  always #5 PCLK = ~PCLK;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0, passed = 0;
  logic [12:0] exp_cmd[$];
  logic [8:0]  resp_q[$];
  logic [7:0]  exp_rd[$], wq0[$], wq1[$];
  logic [1:0]  exp_gnt[$];
  logic [3:0]  exp_done[$];
  int done_cnt = 0, wp_cnt = 0, rv_cnt = 0, t_issue = 0, t_abort = 0, t_done = 0;
  int rem = -1, eng_lat = 2;
  bit seen = 0, eng_hang = 0;
  logic [12:0] cur;
  logic [1:0]  gnt_prev = 2'b00;

  function automatic logic [12:0] mk(input bit s, input bit p, input bit w, input bit r, input bit a, input logic [7:0] d);
    return {s, p, w, r, a, d};
  endfunction
  function automatic logic [12:0] obs();
    return {cmd_start, cmd_stop, cmd_write, cmd_read, cmd_ack, cmd_txd};
  endfunction
  localparam logic [12:0] STOPC = 13'h0800;

  // behavioural engine, requester wdata feed and output scoreboards
  initial begin : model
    logic [12:0] e, m;
    logic [8:0]  rsp;
    logic [7:0]  rd;
    logic [3:0]  ed;
    logic [1:0]  eg;
    forever begin
      @(negedge PCLK);
      cmd_done   = 1'b0;
      core_rxack = 1'b0;
      if (!PRESETn) begin
        seen = 0;
        gnt_prev = 2'b00;
        continue;
      end
      if (!cmd_valid) seen = 0;
      else if (!seen) begin
        seen = 1;
        t_issue = cyc;
        cur = obs();
        rem = eng_lat;
        checks++;
        if (exp_cmd.size() == 0) $display("FAIL cmd_extra: got %h want none", cur);
        else begin
          e = exp_cmd.pop_front();
          m = {4'hF, e[9], e[10] ? 8'hFF : 8'h00};
          if ((cur & m) !== (e & m)) $display("FAIL cmd: got %h want %h (mask %h)", cur, e, m);
          else passed++;
        end
      end else if (rem > 0) rem--;
      if (cmd_valid && seen && !eng_hang && rem == 0) begin
        checks++;
        if (obs() !== cur) $display("FAIL cmd_stable: got %h want %h", obs(), cur);
        else passed++;
        rsp = resp_q.size() != 0 ? resp_q.pop_front() : 9'h000;
        core_rxack = rsp[8];
        core_rxd   = rsp[7:0];
        cmd_done   = 1'b1;
        rem = -1;
      end
      if (rvalid) begin
        rv_cnt++;
        checks++;
        rd = exp_rd.size() != 0 ? exp_rd.pop_front() : 8'hxx;
        if (rdata !== rd) $display("FAIL rdata: got %h want %h", rdata, rd);
        else passed++;
      end
      if (wpop) begin
        wp_cnt++;
        if (gnt[1]) begin
          if (wq1.size() != 0) req_wdata[15:8] = wq1.pop_front();
        end else if (wq0.size() != 0) req_wdata[7:0] = wq0.pop_front();
      end
      if (core_abort) t_abort = cyc;
      if (gnt !== 2'b00 && gnt_prev === 2'b00) begin
        checks++;
        eg = exp_gnt.size() != 0 ? exp_gnt.pop_front() : 2'bxx;
        if (gnt !== eg) $display("FAIL gnt: got %b want %b", gnt, eg);
        else passed++;
      end
      gnt_prev = gnt;
      if (done) begin
        t_done = cyc;
        done_cnt++;
        checks++;
        ed = exp_done.size() != 0 ? exp_done.pop_front() : 4'bxxxx;
        if ({gnt, err_code} !== ed) $display("FAIL done: got gnt/err %b want %b", {gnt, err_code}, ed);
        else passed++;
        if (gnt[0]) req[0] = 1'b0;
        if (gnt[1]) req[1] = 1'b0;
      end
    end
  end

  task automatic drive_req(input int s, input bit rw, input logic [6:0] dev, input logic [7:0] adr,
                           input logic [3:0] len, input logic [7:0] wd);
    req_rw[s] = rw;
    req_dev[s*7 +: 7] = dev;
    req_adr[s*8 +: 8] = adr;
    req_len[s*4 +: 4] = len;
    req_wdata[s*8 +: 8] = wd;
    req[s] = 1'b1;
  endtask

  task automatic exp_hdr(input logic [6:0] dev, input logic [7:0] adr);
    exp_cmd.push_back(mk(1, 0, 1, 0, 0, {dev, 1'b0}));
    exp_cmd.push_back(mk(0, 0, 1, 0, 0, adr));
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge PCLK);
      if (done_cnt >= target) begin
        ok = 1;
        break;
      end
    end
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({gnt, wpop, rvalid, done, err_code, core_abort, rdata} !== '0)
      $display("FAIL reset_outs: got %h want 0", {gnt, wpop, rvalid, done, err_code, core_abort, rdata});
    else passed++;
    checks++;
    if (obs() !== '0 || cmd_valid !== 1'b0) $display("FAIL reset_cmd: got %h/%b want 0/0", obs(), cmd_valid);
    else passed++;
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_write;
    bit ok;
    int base = done_cnt;
    wp_cnt = 0;
    exp_gnt.push_back(2'b01);
    exp_hdr(7'h10, 8'h03);
    exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'hA5));
    exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'h5A));
    exp_cmd.push_back(STOPC);
    exp_done.push_back({2'b01, 2'b00});
    wq0.push_back(8'h5A);
    drive_req(0, 0, 7'h10, 8'h03, 4'd1, 8'hA5);
    wait_done(base + 1, ok);
    checks++;
    if (!ok) $display("FAIL write_done: got none want 1");
    else passed++;
    checks++;
    if (wp_cnt !== 2) $display("FAIL write_wpop: got %0d want 2", wp_cnt);
    else passed++;
    checks++;
    if (exp_cmd.size() !== 0) $display("FAIL write_cmds_left: got %0d want 0", exp_cmd.size());
    else passed++;
  endtask

  task automatic test_data_nack;
    bit ok;
    int base = done_cnt;
    wp_cnt = 0;
    exp_gnt.push_back(2'b01);
    exp_hdr(7'h2A, 8'h80);
    exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'h11));
    exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'h22));
    exp_cmd.push_back(STOPC);
    exp_done.push_back({2'b01, 2'b10});
    resp_q = '{9'h000, 9'h000, 9'h000, 9'h100};
    wq0 = '{8'h22, 8'h33};
    drive_req(0, 0, 7'h2A, 8'h80, 4'd2, 8'h11);
    wait_done(base + 1, ok);
    checks++;
    if (!ok) $display("FAIL dnack_done: got none want 1");
    else passed++;
    checks++;
    if (wp_cnt !== 1) $display("FAIL dnack_wpop: got %0d want 1", wp_cnt);
    else passed++;
    checks++;
    if (exp_cmd.size() !== 0) $display("FAIL dnack_cmds_left: got %0d want 0", exp_cmd.size());
    else passed++;
    wq0.delete();
  endtask

  task automatic test_read;
    bit ok;
    int base = done_cnt;
    rv_cnt = 0;
    exp_gnt.push_back(2'b10);
    exp_hdr(7'h10, 8'h03);
    exp_cmd.push_back(mk(1, 0, 1, 0, 0, 8'h21));
    exp_cmd.push_back(mk(0, 0, 0, 1, 0, 8'h00));
    exp_cmd.push_back(mk(0, 0, 0, 1, 1, 8'h00));
    exp_cmd.push_back(STOPC);
    exp_done.push_back({2'b10, 2'b00});
    resp_q = '{9'h000, 9'h000, 9'h000, 9'h0A5, 9'h05A};
    exp_rd = '{8'hA5, 8'h5A};
    drive_req(1, 1, 7'h10, 8'h03, 4'd1, 8'h00);
    wait_done(base + 1, ok);
    checks++;
    if (!ok) $display("FAIL read_done: got none want 1");
    else passed++;
    checks++;
    if (rv_cnt !== 2) $display("FAIL read_rvalid: got %0d want 2", rv_cnt);
    else passed++;
    checks++;
    if (exp_cmd.size() !== 0) $display("FAIL read_cmds_left: got %0d want 0", exp_cmd.size());
    else passed++;
  endtask

  task automatic test_addr_nack;
    bit ok;
    int base = done_cnt;
    wp_cnt = 0;
    exp_gnt.push_back(2'b10);
    exp_cmd.push_back(mk(1, 0, 1, 0, 0, 8'h22));
    exp_cmd.push_back(STOPC);
    exp_done.push_back({2'b10, 2'b01});
    resp_q = '{9'h100};
    drive_req(1, 0, 7'h11, 8'h05, 4'd0, 8'h99);
    wait_done(base + 1, ok);
    checks++;
    if (!ok) $display("FAIL anack_done: got none want 1");
    else passed++;
    checks++;
    if (wp_cnt !== 0) $display("FAIL anack_wpop: got %0d want 0", wp_cnt);
    else passed++;
    checks++;
    if (exp_cmd.size() !== 0) $display("FAIL anack_cmds_left: got %0d want 0", exp_cmd.size());
    else passed++;
  endtask

  task automatic test_read_long;
    bit ok;
    int base = done_cnt;
    rv_cnt = 0;
    exp_gnt.push_back(2'b10);
    exp_hdr(7'h50, 8'hFF);
    exp_cmd.push_back(mk(1, 0, 1, 0, 0, 8'hA1));
    resp_q = '{9'h000, 9'h000, 9'h000};
    for (int i = 0; i < 16; i++) begin
      exp_cmd.push_back(mk(0, 0, 0, 1, i == 15, 8'h00));
      resp_q.push_back({1'b0, 8'(i * 29 + 3)});
      exp_rd.push_back(8'(i * 29 + 3));
    end
    exp_cmd.push_back(STOPC);
    exp_done.push_back({2'b10, 2'b00});
    drive_req(1, 1, 7'h50, 8'hFF, 4'hF, 8'h00);
    wait_done(base + 1, ok);
    checks++;
    if (!ok) $display("FAIL rlong_done: got none want 1");
    else passed++;
    checks++;
    if (rv_cnt !== 16) $display("FAIL rlong_rvalid: got %0d want 16", rv_cnt);
    else passed++;
    checks++;
    if (exp_cmd.size() !== 0) $display("FAIL rlong_cmds_left: got %0d want 0", exp_cmd.size());
    else passed++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    for (int r = 0; r < 2; r++) begin
      int base = done_cnt;
      exp_gnt.push_back(2'b01);
      exp_gnt.push_back(2'b10);
      exp_hdr(7'h01, 8'(8'h10 + r));
      exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'(8'hC0 + r)));
      exp_cmd.push_back(STOPC);
      exp_hdr(7'h02, 8'(8'h20 + r));
      exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'(8'hD0 + r)));
      exp_cmd.push_back(STOPC);
      exp_done.push_back({2'b01, 2'b00});
      exp_done.push_back({2'b10, 2'b00});
      drive_req(0, 0, 7'h01, 8'(8'h10 + r), 4'd0, 8'(8'hC0 + r));
      drive_req(1, 0, 7'h02, 8'(8'h20 + r), 4'd0, 8'(8'hD0 + r));
      wait_done(base + 2, ok);
      checks++;
      if (!ok) $display("FAIL b2b_done: got %0d want %0d", done_cnt - base, 2);
      else passed++;
      checks++;
      if (exp_gnt.size() !== 0 || exp_done.size() !== 0)
        $display("FAIL b2b_left: got gnt %0d done %0d want 0 0", exp_gnt.size(), exp_done.size());
      else passed++;
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int base = done_cnt;
    eng_hang = 1;
    exp_gnt.push_back(2'b01);
    exp_cmd.push_back(mk(1, 0, 1, 0, 0, 8'h66));
    exp_done.push_back({2'b01, 2'b11});
    drive_req(0, 0, 7'h33, 8'h44, 4'd0, 8'h00);
    wait_done(base + 1, ok);
    eng_hang = 0;
    checks++;
    if (!ok) $display("FAIL to_done: got none want 1");
    else passed++;
    checks++;
    if (t_abort - t_issue !== 20) $display("FAIL to_abort_time: got %0d want 20", t_abort - t_issue);
    else passed++;
    checks++;
    if (t_done !== t_abort) $display("FAIL to_done_time: got %0d want %0d", t_done, t_abort);
    else passed++;
    checks++;
    if (exp_cmd.size() !== 0) $display("FAIL to_cmds_left: got %0d want 0", exp_cmd.size());
    else passed++;
  endtask

  task automatic test_async_reset;
    bit ok;
    int base;
    exp_gnt.push_back(2'b01);
    exp_hdr(7'h10, 8'h03);
    exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'hA5));
    exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'h5A));
    wq0.push_back(8'h5A);
    drive_req(0, 0, 7'h10, 8'h03, 4'd1, 8'hA5);
    for (int i = 0; i < 500; i++) begin
      @(negedge PCLK);
      if (wpop) break;
    end
    @(negedge PCLK);
    checks++;
    if (cmd_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", cmd_valid);
    else passed++;
    base = done_cnt;
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, gnt, wpop} !== 4'b0000) $display("FAIL arst_drop: got %b want 0000", {cmd_valid, gnt, wpop});
    else passed++;
    req = 2'b00;
    exp_cmd.delete();
    resp_q.delete();
    wq0.delete();
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    checks++;
    if (done_cnt !== base) $display("FAIL arst_no_done: got %0d want %0d", done_cnt, base);
    else passed++;
    exp_gnt.push_back(2'b01);
    exp_hdr(7'h12, 8'h34);
    exp_cmd.push_back(mk(0, 0, 1, 0, 0, 8'h77));
    exp_cmd.push_back(STOPC);
    exp_done.push_back({2'b01, 2'b00});
    drive_req(0, 0, 7'h12, 8'h34, 4'd0, 8'h77);
    wait_done(base + 1, ok);
    checks++;
    if (!ok) $display("FAIL arst_fresh_done: got none want 1");
    else passed++;
    checks++;
    if (exp_cmd.size() !== 0) $display("FAIL arst_cmds_left: got %0d want 0", exp_cmd.size());
    else passed++;
  endtask

  initial begin
    PRESETn = 1'b0;
    req = '0; req_rw = '0; req_dev = '0; req_adr = '0; req_len = '0; req_wdata = '0;
    cmd_done = 1'b0; core_rxd = '0; core_rxack = 1'b0;
    test_reset;
    test_write;
    test_data_nack;
    test_read;
    test_addr_nack;
    test_read_long;
    test_back_to_back;
    test_timeout;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
